led_pattern_seq: RTL and testbench
==================================

Name: led_pattern_seq

Overview:
- Downstream consumer of the selectable-rate clock divider.
- Takes the divider's slow square-wave output, synchronises it into the `clk` domain and converts each rising edge into a one-cycle step tick.
- Each step tick advances an LED pattern: rotate left, rotate right, ping-pong, or bar fill, selected by `mode`.
- Drives the board LEDs directly.

Parameters:
- N_LED, 8: number of LEDs / pattern width; legal values are 2 or more.
- SYNC_STAGES, 2: flip-flop stages in the `step_in` synchroniser; legal values are 2 or more.

Ports:
- clk  input  1  system clock; all logic is on its rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset asserted).
- step_in  input  1  slow divided clock from the divider; treated as asynchronous.
- mode  input  2  pattern select: 0 = rotate left, 1 = rotate right, 2 = ping-pong, 3 = bar fill.
- run  input  1  1 = pattern advances on ticks; 0 = pattern frozen.
- led  output  N_LED  registered LED pattern.
- step_tick  output  1  registered one-cycle pulse for each accepted `step_in` rising edge.

Behaviour:
- Reset (`reset` = 0 sampled at a `clk` edge):
  - `led` = seed of mode 0 = 0x01.
  - Direction register = left.
  - `mode_q` = 0.
  - Synchroniser flops = 0, edge register = 0, `armed` = 0.
  - `step_tick` = 0.
- Synchroniser and edge detect:
  - `step_in` passes through SYNC_STAGES flops to give `s`.
  - `prev` holds `s` delayed by one cycle.
  - `armed` is set on the first cycle `s` = 0 after reset. This prevents a spurious tick if `step_in` is already high when reset is released.
  - Internal `tick` = `s` & ~`prev` & `armed`.
- Latency: the first `clk` edge that samples `step_in` high is edge k. `step_tick` and the updated `led` both become visible after edge k+SYNC_STAGES+1, i.e. edge k+3 by default.
- `step_tick`:
  - High for exactly one cycle per accepted edge, independent of `run` and `mode`.
  - Successive ticks are at least 2 cycles apart.
- Mode reload:
  - `mode_q` registers `mode` every cycle.
  - When `mode` != `mode_q`, on that edge: `led` is loaded with the new mode's seed, direction is set to left, and `mode_q` is updated.
  - Reload takes priority over a coincident tick; the tick still pulses `step_tick` but does not advance the pattern.
  - Reload occurs even when `run` = 0.
- Seeds: mode 0 = 0x01, mode 1 = 0x80 (MSB only), mode 2 = 0x01, mode 3 = 0x00. Values shown for N_LED = 8; generalise by width.
- Advance: on `tick` & `run` & no reload:
  - Mode 0: rotate left by one; the MSB wraps to the LSB.
  - Mode 1: rotate right by one; the LSB wraps to the MSB.
  - Mode 2, direction left: if `led`[N_LED-1] is set, shift right by one and set direction = right; otherwise shift left by one.
  - Mode 2, direction right: if `led`[0] is set, shift left by one and set direction = left; otherwise shift right by one.
  - Mode 2 therefore has period 2·(N_LED−1) ticks and the end LEDs are never lit twice in a row.
  - Mode 3: if `led` is all ones, load 0; otherwise `led` = {`led`[N_LED-2:0], 1}. Period is N_LED+1 ticks.
- Freeze: when `run` = 0, ticks leave `led` and direction unchanged.
- Reset mid-operation: reset applied at any point, including during a tick or a reload, fully re-initialises the block. `armed` must be re-established before the next tick is accepted.
- Width rules:
  - All shifts are N_LED-bit with no carry out.
  - The `led` state can never be all-zero in modes 0–2 unless a reload supplies it. Modes 0–2 seeds are one-hot, so this never occurs.

Decomposition:
- Package `led_pkg`:
  - Mode constants MODE_ROT_L = 2'd0, MODE_ROT_R = 2'd1, MODE_PING = 2'd2, MODE_FILL = 2'd3.
  - Direction constants DIR_LEFT = 1'b0, DIR_RIGHT = 1'b1.
- Sub-module `step_sync_edge`:
  - Contents: SYNC_STAGES synchroniser, `prev` register, `armed` flag, and tick output.
  - Parameterised by SYNC_STAGES; takes the same `clk`/`reset`.
  - Reusable for the button inputs.

Test Plan:
- Reset with `step_in` high:
  - Stimulus: hold `reset` = 0 for 4 cycles with `step_in` = 1, then release.
  - Response: `led` = 0x01 and no `step_tick` while `step_in` stays high.
  - Then drive `step_in` low for 5 cycles, then high.
  - Response: exactly one `step_tick`, 3 cycles after the first sampled-high edge.
- Rotate left:
  - Stimulus: `mode` = 0, `run` = 1, 9 `step_in` pulses (each 10 cycles high, 10 low).
  - Response: `led` sequence 02, 04, 08, 10, 20, 40, 80, 01, 02.
- Ping-pong:
  - Stimulus: `mode` = 2, 16 pulses.
  - Response: 02, 04, 08, 10, 20, 40, 80, 40, 20, 10, 08, 04, 02, 01, 02, 04.
- Bar fill:
  - Stimulus: `mode` = 3, 10 pulses.
  - Response: 01, 03, 07, 0F, 1F, 3F, 7F, FF, 00, 01.
- Mode change coincident with tick:
  - Stimulus: `mode` 0 → 1 on the same edge an internal tick fires.
  - Response: `led` = 0x80, `step_tick` = 1 for that cycle, no rotation applied.
  - Next tick gives `led` = 0x40.
- Freeze and reset mid-pattern:
  - Stimulus: `run` = 0 for 5 pulses.
  - Response: `led` unchanged, 5 `step_tick` pulses.
  - Stimulus: assert `reset` = 0 for 1 cycle on a tick edge.
  - Response: `led` = 0x01, `step_tick` = 0.

Source files
------------

// File: rtl/led_pkg.sv
// Shared constants for the LED pattern sequencer: pattern modes and
// ping-pong direction encoding.
package led_pkg;

  localparam logic [1:0] MODE_ROT_L = 2'd0;
  localparam logic [1:0] MODE_ROT_R = 2'd1;
  localparam logic [1:0] MODE_PING  = 2'd2;
  localparam logic [1:0] MODE_FILL  = 2'd3;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/step_sync_edge.sv
// Synchronises an asynchronous slow input into clk and emits a registered
// one-cycle tick per rising edge, suppressed until a real low level is seen.
module step_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic step_in,
  output logic tick
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] fill_q;
  logic                   prev_q;
  logic                   armed_q;
  logic                   tick_q;
  logic                   s;
  logic                   fill_done;

  assign s         = sync_q[SYNC_STAGES-1];
  assign fill_done = fill_q[SYNC_STAGES-1];
  assign tick      = tick_q;

  // fill_q marks when s holds a genuine sample rather than a reset zero,
  // so a step_in held high across reset cannot arm and fire a false tick.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q  <= '0;
      fill_q  <= '0;
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], step_in};
      fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      prev_q <= s;
      if (fill_done && !s) armed_q <= 1'b1;
      tick_q <= s & ~prev_q & armed_q;
    end
  end

endmodule

// File: rtl/led_pattern_seq.sv
// LED pattern sequencer: each synchronised step_in rising edge advances a
// rotate / ping-pong / bar-fill pattern chosen by mode.
module led_pattern_seq
  import led_pkg::*;
#(
  parameter int N_LED       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step_in,
  input  logic [1:0]       mode,
  input  logic             run,
  output logic [N_LED-1:0] led,
  output logic             step_tick
);

  localparam logic [N_LED-1:0] LSB_ONE = N_LED'(1);
  localparam logic [N_LED-1:0] MSB_ONE = LSB_ONE << (N_LED - 1);

  logic [N_LED-1:0] led_q, led_n;
  logic             dir_q, dir_n;
  logic [1:0]       mode_q;
  logic             step_tick_q;
  logic             tick;
  logic             reload;

  function automatic logic [N_LED-1:0] seed_of(input logic [1:0] m);
    logic [N_LED-1:0] v;
    unique case (m)
      MODE_ROT_R: v = MSB_ONE;
      MODE_FILL:  v = '0;
      default:    v = LSB_ONE;
    endcase
    return v;
  endfunction

  step_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk     (clk),
    .reset   (reset),
    .step_in (step_in),
    .tick    (tick)
  );

  assign reload    = (mode != mode_q);
  assign led       = led_q;
  assign step_tick = step_tick_q;

  // A mode change wins over a coincident tick; the tick is still reported.
  always_comb begin
    led_n = led_q;
    dir_n = dir_q;
    if (reload) begin
      led_n = seed_of(mode);
      dir_n = DIR_LEFT;
    end else if (tick && run) begin
      unique case (mode_q)
        MODE_ROT_L: led_n = {led_q[N_LED-2:0], led_q[N_LED-1]};
        MODE_ROT_R: led_n = {led_q[0], led_q[N_LED-1:1]};
        MODE_PING: begin
          if (dir_q == DIR_LEFT) begin
            if (led_q[N_LED-1]) begin
              led_n = led_q >> 1;
              dir_n = DIR_RIGHT;
            end else begin
              led_n = led_q << 1;
            end
          end else begin
            if (led_q[0]) begin
              led_n = led_q << 1;
              dir_n = DIR_LEFT;
            end else begin
              led_n = led_q >> 1;
            end
          end
        end
        MODE_FILL: begin
          if (&led_q) led_n = '0;
          else        led_n = {led_q[N_LED-2:0], 1'b1};
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      led_q       <= LSB_ONE;
      dir_q       <= DIR_LEFT;
      mode_q      <= MODE_ROT_L;
      step_tick_q <= 1'b0;
    end else begin
      led_q       <= led_n;
      dir_q       <= dir_n;
      mode_q      <= mode;
      step_tick_q <= tick;
    end
  end

endmodule

// File: tb/tb_led_pattern_seq.sv
// Self-checking bench for led_pattern_seq with a position-based pattern model.
module tb_led_pattern_seq;

  localparam int N = 8;

  logic         clk;
  logic         reset;
  logic         step_in;
  logic [1:0]   mode;
  logic         run;
  logic [N-1:0] led;
  logic         step_tick;

  int n_tests;
  int n_fail;

  // model: current mode and number of advances since the last seed load
  int m_mode;
  int m_cnt;

  led_pattern_seq #(.N_LED(N), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .step_in   (step_in),
    .mode      (mode),
    .run       (run),
    .led       (led),
    .step_tick (step_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pattern as a function of step count: rotations are a moving bit index,
  // ping-pong is a triangle wave over the positions, fill is a growing bar.
  function automatic logic [N-1:0] model_led(input int m, input int c);
    int p;
    int idx;
    logic [N-1:0] one;
    one = 1;
    case (m)
      0: return one << (c % N);
      1: return one << (N - 1 - (c % N));
      2: begin
        p   = c % (2 * (N - 1));
        idx = (p <= N - 1) ? p : 2 * (N - 1) - p;
        return one << idx;
      end
      default: begin
        p = c % (N + 1);
        return (one << p) - 1;
      end
    endcase
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset   = 1'b0;
    step_in = 1'b0;
    mode    = 2'd0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (6) @(negedge clk);
    m_mode = 0;
    m_cnt  = 0;
  endtask

  task automatic pulse(input int hi, input int lo, output int ticks);
    ticks   = 0;
    step_in = 1'b1;
    repeat (hi) begin
      @(negedge clk);
      if (step_tick) ticks++;
    end
    step_in = 1'b0;
    repeat (lo) begin
      @(negedge clk);
      if (step_tick) ticks++;
    end
  endtask

  task automatic check_pulse(input string name);
    int ticks;
    logic [N-1:0] exp;
    pulse($urandom_range(3, 12), $urandom_range(3, 12), ticks);
    if (run) m_cnt++;
    exp = model_led(m_mode, m_cnt);
    n_tests++;
    if (ticks !== 1) begin
      n_fail++;
      $display("FAIL %s tick_count: got %0d expected 1", name, ticks);
    end
    n_tests++;
    if (led !== exp) begin
      n_fail++;
      $display("FAIL %s led: got %02h expected %02h (mode %0d step %0d)",
               name, led, exp, m_mode, m_cnt);
    end
  endtask

  task automatic set_mode(input int m);
    logic [N-1:0] exp;
    mode = m[1:0];
    @(negedge clk);
    @(negedge clk);
    if (m != m_mode) begin
      m_mode = m;
      m_cnt  = 0;
    end
    exp = model_led(m_mode, m_cnt);
    n_tests++;
    if (led !== exp) begin
      n_fail++;
      $display("FAIL mode_reload led: got %02h expected %02h (mode %0d)", led, exp, m);
    end
  endtask

  task automatic test_reset();
    int ticks;
    int first;
    @(negedge clk);
    reset   = 1'b0;
    step_in = 1'b1;
    mode    = 2'd0;
    run     = 1'b1;
    repeat (4) @(negedge clk);
    n_tests++;
    if (led !== 8'h01 || step_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: led=%02h tick=%b expected led=01 tick=0", led, step_tick);
    end
    reset  = 1'b1;
    m_mode = 0;
    m_cnt  = 0;
    ticks  = 0;
    repeat (10) begin
      @(negedge clk);
      if (step_tick) ticks++;
    end
    n_tests++;
    if (ticks !== 0 || led !== 8'h01) begin
      n_fail++;
      $display("FAIL reset_high_no_tick: ticks=%0d led=%02h expected ticks=0 led=01", ticks, led);
    end
    step_in = 1'b0;
    repeat (5) @(negedge clk);
    step_in = 1'b1;
    ticks   = 0;
    first   = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (step_tick) begin
        ticks++;
        if (first == 0) first = i;
      end
    end
    step_in = 1'b0;
    repeat (6) @(negedge clk);
    m_cnt = 1;
    n_tests++;
    if (ticks !== 1 || first !== 4) begin
      n_fail++;
      $display("FAIL first_tick_latency: ticks=%0d at %0d expected 1 at 4", ticks, first);
    end
    n_tests++;
    if (led !== model_led(0, 1)) begin
      n_fail++;
      $display("FAIL first_tick_led: got %02h expected %02h", led, model_led(0, 1));
    end
  endtask

  task automatic test_rotate_left();
    do_reset();
    run = 1'b1;
    for (int i = 0; i < 9; i++) check_pulse("rotate_left");
  endtask

  task automatic test_rotate_right();
    set_mode(1);
    for (int i = 0; i < 9; i++) check_pulse("rotate_right");
  endtask

  task automatic test_ping_pong();
    set_mode(2);
    for (int i = 0; i < 16; i++) check_pulse("ping_pong");
  endtask

  task automatic test_bar_fill();
    set_mode(3);
    for (int i = 0; i < 10; i++) check_pulse("bar_fill");
  endtask

  task automatic test_mode_coincident();
    do_reset();
    run = 1'b1;
    check_pulse("coincident_pre");
    check_pulse("coincident_pre");
    step_in = 1'b1;
    repeat (3) @(negedge clk);
    mode = 2'd1;
    @(negedge clk);
    m_mode = 1;
    m_cnt  = 0;
    n_tests++;
    if (step_tick !== 1'b1 || led !== 8'h80) begin
      n_fail++;
      $display("FAIL coincident_reload: tick=%b led=%02h expected tick=1 led=80", step_tick, led);
    end
    repeat (6) @(negedge clk);
    step_in = 1'b0;
    repeat (8) @(negedge clk);
    check_pulse("coincident_next");
  endtask

  task automatic test_freeze_reset();
    logic [N-1:0] held;
    int ticks;
    set_mode(2);
    run = 1'b1;
    for (int i = 0; i < 3; i++) check_pulse("freeze_pre");
    run  = 1'b0;
    held = led;
    for (int i = 0; i < 5; i++) check_pulse("freeze");
    n_tests++;
    if (led !== held) begin
      n_fail++;
      $display("FAIL freeze_hold: got %02h expected %02h", led, held);
    end
    run = 1'b1;
    check_pulse("unfreeze");
    // reset sampled on the edge where the tick would land
    step_in = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    mode  = 2'd0;
    @(negedge clk);
    reset = 1'b1;
    n_tests++;
    if (led !== 8'h01 || step_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_on_tick: led=%02h tick=%b expected led=01 tick=0", led, step_tick);
    end
    m_mode = 0;
    m_cnt  = 0;
    ticks  = 0;
    repeat (8) begin
      @(negedge clk);
      if (step_tick) ticks++;
    end
    n_tests++;
    if (ticks !== 0) begin
      n_fail++;
      $display("FAIL rearm_after_reset: ticks=%0d expected 0", ticks);
    end
    step_in = 1'b0;
    repeat (6) @(negedge clk);
    check_pulse("after_reset");
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 3) == 0) set_mode($urandom_range(0, 3));
      run = ($urandom_range(0, 4) != 0);
      check_pulse("random");
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b0;
    step_in = 1'b0;
    mode    = 2'd0;
    run     = 1'b0;
    m_mode  = 0;
    m_cnt   = 0;
    test_reset();
    test_rotate_left();
    test_rotate_right();
    test_ping_pong();
    test_bar_fill();
    test_mode_coincident();
    test_freeze_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
